sipo_deserializer: RTL
======================

// Module: sipo_deserializer
// PURPOSE
//  Serial-in / parallel-out shift register with word framing. Accepts one serial
//  bit per clk when sin_valid is high and assembles N-bit words. Presents each
//  completed word on a held parallel output with a one-cycle q_valid strobe.
//  Receive end of a serial link; feeds the team's n-bit parallel registers.
// PARAMETERS
//  N          4   word width in bits (N >= 2)
//  MSB_FIRST  1   1: first accepted bit lands in q[N-1]; 0: first bit lands in q[0]
// PORTS
//  clk        in   1          rising-edge clock; sole clock domain
//  rst        in   1          reset; synchronous, active-high
//  sin        in   1          serial data bit
//  sin_valid  in   1          sin is sampled on this clk edge
//  clear      in   1          synchronous abort of the partial word
//  q          out  N          last completed word; held until the next word completes
//  q_valid    out  1          one-cycle strobe: q updated this cycle
//  bit_cnt    out  CW         bits held in the partial word (0..N-1); CW = $clog2(N)
//  busy       out  1          bit_cnt != 0
// BEHAVIOUR
//  - Reset, rst high at a clk edge: q=0, q_valid=0, bit_cnt=0, busy=0, internal shreg=0.
//    rst has priority over clear and sin_valid. rst mid-word discards the partial bits.
//  - clear high (rst low): bit_cnt->0 and shreg->0. q is unchanged. q_valid->0.
//    sin_valid on that edge is ignored. clear has priority over sin_valid.
//  - sin_valid high, bit_cnt < N-1:
//    - MSB_FIRST=1: shreg <= {shreg[N-2:0], sin}.
//    - MSB_FIRST=0: shreg <= {sin, shreg[N-1:1]}.
//    - bit_cnt increments; q_valid=0.
//  - sin_valid high, bit_cnt == N-1 (final bit):
//    - q <= the completed word, including this bit.
//    - q_valid=1 for exactly one cycle; bit_cnt wraps to 0; shreg <= 0.
//  - Latency: q and q_valid are visible the cycle after the edge that samples the final bit.
//  - sin_valid low: shreg and bit_cnt hold; q_valid=0. Gaps of any length are allowed
//    inside a word.
//  - Back-to-back words with no idle cycle: the first bit of word k+1 may be sampled on
//    the cycle right after word k's final bit. q_valid then pulses every N cycles, never
//    stuck high.
//  - No overflow exists. The word is committed on the final bit, so the receiver never
//    stalls.
//  - q_valid is registered. All outputs change only on clk edges.
//  - busy is combinational from bit_cnt.
//  - State is implicit in bit_cnt: IDLE (0) -> COLLECT (1..N-1) -> commit -> IDLE.
// TESTING (N=4 unless noted)
//  1 rst=1 for 2 clk with sin_valid=1, sin=1 -> q=0, q_valid=0, bit_cnt=0 throughout.
//  2 MSB_FIRST=1; sin 1,0,1,0 on 4 consecutive valid cycles ->
//    q=4'b1010 with q_valid=1 for one cycle after the 4th edge; bit_cnt 1,2,3,0.
//  3 MSB_FIRST=0; same stream -> q=4'b0101; then sin_valid low for 3 cycles ->
//    q holds 4'b0101, q_valid=0.
//  4 Back-to-back 1111 then 0011 (MSB first), no gaps ->
//    q=4'b1111 then q=4'b0011, q_valid pulses exactly 4 cycles apart.
//  5 Send 1,1 then clear=1 with sin_valid=1, then 0,1,1,0 ->
//    bit_cnt=0 after clear; q=4'b0110; the prior q is unchanged until then.
//  6 rst pulsed after 3 bits of a word, then 1,0,0,1 ->
//    no q_valid from the partial word; q=4'b1001.
//  7 Random: 40 cycles of $random sin/sin_valid ->
//    a reference-model scoreboard matches every q/q_valid pair.

Source files
------------

// File: rtl/sipo_deserializer.sv
// sipo_deserializer: serial-in/parallel-out word assembler; clk, rst, sin, sin_valid, clear in; q, q_valid, bit_cnt, busy out
module sipo_deserializer #(
  parameter int N = 4,
  parameter bit MSB_FIRST = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sin,
  input  logic                 sin_valid,
  input  logic                 clear,
  output logic [N-1:0]         q,
  output logic                 q_valid,
  output logic [$clog2(N)-1:0] bit_cnt,
  output logic                 busy
);
  localparam int CW = $clog2(N);
  logic [N-1:0] shreg;
  logic [N-1:0] nxt;
  logic         last;
  assign nxt  = MSB_FIRST ? {shreg[N-2:0], sin} : {sin, shreg[N-1:1]};
  assign last = bit_cnt == CW'(N - 1);
  assign busy = bit_cnt != '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      q       <= '0;
      q_valid <= 1'b0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (clear) begin
      q_valid <= 1'b0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      q_valid <= sin_valid && last;
      if (sin_valid && last) begin
        q       <= nxt;
        shreg   <= '0;
        bit_cnt <= '0;
      end else if (sin_valid) begin
        shreg   <= nxt;
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end
endmodule
